// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port round-robin arbiter in front of a single-port memory.
//            Each grant is one ACCESS cycle, reads add one RESP cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] adr0,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] DataAdr,
  output logic [DW-1:0] WriteData,
  output logic          MemWrite,
  input  logic [DW-1:0] ReadData,
  output logic          busy
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_access = 2'd1;
  localparam logic [1:0] c_st_resp   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] rd0_q, rd0_d;
  logic [DW-1:0] rd1_q, rd1_d;

  logic w_any_req;
  logic w_arb_win;

  assign w_any_req = req0 | req1;
  // Under contention the port that did not win last time goes next.
  assign w_arb_win = (req0 && req1) ? ~last_grant_q : req1;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:   state_d = w_any_req ? c_st_access : c_st_idle;
      c_st_access: state_d = we_q ? c_st_idle : c_st_resp;
      c_st_resp:   state_d = c_st_idle;
      default:     state_d = c_st_idle;
    endcase
  end

  // Request latch, round-robin history and read-data capture
  always_comb begin
    last_grant_d = last_grant_q;
    win_d        = win_q;
    we_d         = we_q;
    adr_d        = adr_q;
    wd_d         = wd_q;
    rd0_d        = rd0_q;
    rd1_d        = rd1_q;
    if (state_q == c_st_idle && w_any_req) begin
      win_d        = w_arb_win;
      last_grant_d = w_arb_win;
      we_d         = w_arb_win ? we1  : we0;
      adr_d        = w_arb_win ? adr1 : adr0;
      wd_d         = w_arb_win ? wd1  : wd0;
    end
    if (state_q == c_st_access && !we_q) begin
      if (win_q) begin
        rd1_d = ReadData;
      end else begin
        rd0_d = ReadData;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      wd_q         <= '0;
      rd0_q        <= '0;
      rd1_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      wd_q         <= wd_d;
      rd0_q        <= rd0_d;
      rd1_q        <= rd1_d;
    end
  end

  // Outputs decode from state only, so a reset clears them without a clock.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    busy      = (state_q != c_st_idle);
    case (state_q)
      c_st_access: begin
        gnt0      = ~win_q;
        gnt1      = win_q;
        MemWrite  = we_q;
        DataAdr   = adr_q;
        WriteData = wd_q;
      end
      c_st_resp: begin
        rvalid0 = ~win_q;
        rvalid1 = win_q;
      end
      default: ;
    endcase
  end

  assign rd0 = rd0_q;
  assign rd1 = rd1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench: directed cases plus randomized requesters
//            compared every cycle against a transaction-level schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] adr0, adr1;
  logic [DW-1:0] wd0, wd1;
  logic          gnt0, gnt1, rvalid0, rvalid1, MemWrite, busy;
  logic [DW-1:0] rd0, rd1, WriteData, ReadData;
  logic [AW-1:0] DataAdr;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .rd0(rd0), .rd1(rd1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .DataAdr(DataAdr), .WriteData(WriteData), .MemWrite(MemWrite),
    .ReadData(ReadData), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Environment memory (drives ReadData) and the model's own copy.
  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] mod_mem [256];
  assign ReadData = env_mem[DataAdr[7:0]];
  always @(posedge CLK) if (MemWrite) env_mem[DataAdr[7:0]] <= WriteData;

  int checks = 0;
  int errors = 0;

  // Expected outputs for a given cycle, scheduled when a request is accepted.
  typedef struct packed {
    logic          gnt0, gnt1, mw, rv0, rv1, busy, rdcap, port;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t          ring [4];
  logic [DW-1:0] exp_rd [2];
  int            cyc      = 0;
  int            next_arb = 0;
  logic          last     = 1'b1;

  always @(posedge CLK) begin : model
    int            c;
    exp_t          e;
    logic          w, m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_wd;
    c = cyc;
    if (RESET) begin
      for (int i = 0; i < 4; i++) ring[i] = '0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      last      = 1'b1;
      next_arb  = c + 1;
    end else begin
      e = ring[c % 4];
      if (e.mw)    mod_mem[e.adr[7:0]] = e.wd;
      if (e.rdcap) exp_rd[e.port] = mod_mem[e.adr[7:0]];
      ring[c % 4] = '0;
      if (c >= next_arb && (req0 || req1)) begin
        w     = (req0 && req1) ? !last : req1;
        last  = w;
        m_we  = w ? we1  : we0;
        m_adr = w ? adr1 : adr0;
        m_wd  = w ? wd1  : wd0;
        ring[(c+1)%4].gnt0  = !w;
        ring[(c+1)%4].gnt1  = w;
        ring[(c+1)%4].mw    = m_we;
        ring[(c+1)%4].adr   = m_adr;
        ring[(c+1)%4].wd    = m_wd;
        ring[(c+1)%4].busy  = 1'b1;
        ring[(c+1)%4].rdcap = !m_we;
        ring[(c+1)%4].port  = w;
        if (m_we) begin
          next_arb = c + 2;
        end else begin
          ring[(c+2)%4].rv0  = !w;
          ring[(c+2)%4].rv1  = w;
          ring[(c+2)%4].busy = 1'b1;
          next_arb = c + 3;
        end
      end
    end
    cyc = c + 1;
    #1;
    e = ring[cyc % 4];
    checks++;
    if ({gnt0, gnt1, MemWrite, rvalid0, rvalid1, busy} !== {e.gnt0, e.gnt1, e.mw, e.rv0, e.rv1, e.busy} ||
        DataAdr !== e.adr || WriteData !== e.wd || rd0 !== exp_rd[0] || rd1 !== exp_rd[1]) begin
      errors++;
      $display("FAIL cycle%0d: got gnt=%b%b mw=%b adr=%h wd=%h rv=%b%b busy=%b rd0=%h rd1=%h; expected gnt=%b%b mw=%b adr=%h wd=%h rv=%b%b busy=%b rd0=%h rd1=%h",
               cyc, gnt0, gnt1, MemWrite, DataAdr, WriteData, rvalid0, rvalid1, busy, rd0, rd1,
               e.gnt0, e.gnt1, e.mw, e.adr, e.wd, e.rv0, e.rv1, e.busy, exp_rd[0], exp_rd[1]);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic start_req(input int p);
    logic [AW-1:0] a;
    a = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
    if (p == 0) begin
      req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); adr0 = a; wd0 = $urandom;
    end else begin
      req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); adr1 = a; wd1 = $urandom;
    end
  endtask

  initial begin : stim
    logic [DW-1:0] old;
    int            seq [4];
    int            n;
    int            pct;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom;
      mod_mem[i] = env_mem[i];
    end
    RESET = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    adr0 = '0; adr1 = '0; wd0 = '0; wd1 = '0;

    // Reset state
    #21;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_strobes", 64'({gnt0, gnt1, rvalid0, rvalid1, MemWrite}), 64'd0);
    chk("reset_adr_wd", 64'({DataAdr, WriteData}), 64'd0);
    chk("reset_rd", 64'({rd0, rd1}), 64'd0);
    #1 RESET = 1'b0;
    @(posedge CLK); #2;
    chk("idle_busy", 64'(busy), 64'd0);

    // Single write from port 0
    @(negedge CLK); req0 = 1; we0 = 1; adr0 = 32'h64; wd0 = 32'd7;
    @(posedge CLK); #2;
    chk("wr_gnt0", 64'({gnt0, gnt1}), 64'b10);
    chk("wr_memwrite", 64'(MemWrite), 64'd1);
    chk("wr_adr", 64'(DataAdr), 64'h64);
    chk("wr_data", 64'(WriteData), 64'd7);
    @(negedge CLK); req0 = 0;
    @(posedge CLK); #2;
    chk("wr_done_busy", 64'(busy), 64'd0);
    chk("wr_mem", 64'(env_mem[8'h64]), 64'd7);

    // Single read from port 1
    @(negedge CLK); req1 = 1; we1 = 0; adr1 = 32'h64;
    @(posedge CLK); #2;
    chk("rd_gnt1", 64'({gnt0, gnt1}), 64'b01);
    chk("rd_memwrite", 64'(MemWrite), 64'd0);
    @(negedge CLK); req1 = 0;
    @(posedge CLK); #2;
    chk("rd_rvalid", 64'({rvalid0, rvalid1}), 64'b01);
    chk("rd_rd1", 64'(rd1), 64'd7);
    chk("rd_rd0_held", 64'(rd0), 64'd0);
    @(posedge CLK); #2;
    chk("rd_done_busy", 64'(busy), 64'd0);

    // Address change while in ACCESS is ignored
    @(negedge CLK); req0 = 1; we0 = 0; adr0 = 32'h10;
    @(posedge CLK); #2;
    chk("chg_gnt0", 64'(gnt0), 64'd1);
    @(negedge CLK); adr0 = 32'h20; req0 = 0;
    #1 chk("chg_adr_latched", 64'(DataAdr), 64'h10);
    @(posedge CLK); #2;
    chk("chg_rvalid0", 64'(rvalid0), 64'd1);
    @(posedge CLK);

    // Reset in the middle of a write ACCESS
    @(negedge CLK); req0 = 1; we0 = 1; adr0 = 32'h30; wd0 = 32'hDEAD_BEEF;
    old = env_mem[8'h30];
    @(posedge CLK); #2;
    chk("rst_mw_before", 64'(MemWrite), 64'd1);
    #1 RESET = 1'b1;
    #1;
    chk("rst_mw_async", 64'(MemWrite), 64'd0);
    chk("rst_busy_async", 64'(busy), 64'd0);
    chk("rst_gnt_async", 64'({gnt0, gnt1, DataAdr}), 64'd0);
    req0 = 0;
    @(posedge CLK); #2;
    @(negedge CLK); RESET = 1'b0;
    chk("rst_mem_kept", 64'(env_mem[8'h30]), 64'(old));

    // Contention right after reset: strict 0,1,0,1
    @(negedge CLK); req0 = 1; req1 = 1; we0 = 0; we1 = 0; adr0 = 32'h40; adr1 = 32'h41;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(posedge CLK); #2;
      if (gnt0) begin seq[n] = 0; n++; end
      else if (gnt1) begin seq[n] = 1; n++; end
    end
    chk("cont_count", 64'(n), 64'd4);
    for (int i = 0; i < 4 && i < n; i++) chk("cont_order", 64'(seq[i]), 64'(i % 2));
    @(negedge CLK); req0 = 0; req1 = 0;
    repeat (3) @(negedge CLK);

    // Randomized requesters: sparse, then saturating
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK);
      pct = (k < 1500) ? 25 : 100;
      if (gnt0) req0 = 0;
      if (gnt1) req1 = 0;
      if (!req0 && $urandom_range(0, 99) < pct) start_req(0);
      if (!req1 && $urandom_range(0, 99) < pct) start_req(1);
    end
    req0 = 0; req1 = 0;
    repeat (5) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
